// File: rtl/puf_pkg.sv
// Shared constants and FSM encoding for the PUF delay-line calibration controller.
package puf_pkg;

    localparam int PDL_CONFIG_WIDTH_DEF = 128;
    localparam int CHALLENGE_WIDTH_DEF  = 32;
    localparam int N_SAMPLES_DEF        = 64;
    localparam int TOL_DEF              = 4;
    localparam int DONE_TIMEOUT_DEF     = 255;
    // Sample and ones counters; N_SAMPLES is capped at 128 so they never wrap.
    localparam int CNT_W                = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_TRIG,
        ST_WAIT,
        ST_EVAL,
        ST_FINISH
    } calib_state_e;

endpackage

// File: rtl/puf_calib_ctrl_if.sv
// Controller-to-PUF evaluation bus.
// Handshake: puf_trigger is a one-cycle request with puf_challenge already valid; the PUF answers
// with a one-cycle puf_done carrying puf_xor_response; only one evaluation is outstanding at a time.
interface puf_calib_ctrl_if
    import puf_pkg::*;
#(
    parameter int CHALLENGE_WIDTH = CHALLENGE_WIDTH_DEF
);
    logic                       puf_trigger;
    logic [CHALLENGE_WIDTH-1:0] puf_challenge;
    logic                       puf_done;
    logic                       puf_xor_response;

    modport master (
        output puf_trigger,
        output puf_challenge,
        input  puf_done,
        input  puf_xor_response
    );

    modport slave (
        input  puf_trigger,
        input  puf_challenge,
        output puf_done,
        output puf_xor_response
    );
endinterface

// File: rtl/therm_enc.sv
// Tap index to thermometer code: the low i_idx bits set, the rest clear.
module therm_enc
    import puf_pkg::*;
#(
    parameter int  WIDTH = PDL_CONFIG_WIDTH_DEF,
    localparam int IDX_W = $clog2(WIDTH + 1)
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [WIDTH-1:0] o_therm
);
    // A shift of WIDTH or more yields zero, so i_idx == WIDTH gives all ones.
    assign o_therm = ~({WIDTH{1'b1}} << i_idx);
endmodule

// File: rtl/puf_calib_ctrl.sv
// Sweeps the PDL tap setting upward until a tap gives a balanced PUF response
// (ones count within TOL of N_SAMPLES/2), or the sweep is exhausted / the PUF stops answering.
module puf_calib_ctrl
    import puf_pkg::*;
#(
    parameter int  PDL_CONFIG_WIDTH = PDL_CONFIG_WIDTH_DEF,
    parameter int  CHALLENGE_WIDTH  = CHALLENGE_WIDTH_DEF,
    parameter int  N_SAMPLES        = N_SAMPLES_DEF,
    parameter int  TOL              = TOL_DEF,
    parameter int  DONE_TIMEOUT     = DONE_TIMEOUT_DEF,
    localparam int TAP_W            = $clog2(PDL_CONFIG_WIDTH + 1)
) (
    input  logic                        clk_1,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CHALLENGE_WIDTH-1:0]  chal_in,
    puf_calib_ctrl_if.master            puf,
    output logic [PDL_CONFIG_WIDTH-1:0] pdl_config,
    output logic                        busy,
    output logic                        calib_done,
    output logic                        calib_ok,
    output logic                        timeout_err,
    output logic [TAP_W-1:0]            locked_tap,
    output logic [7:0]                  last_ones,
    output calib_state_e                dbg_state
);
    localparam int WCNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam int HALF   = N_SAMPLES / 2;

    calib_state_e                r_state;
    calib_state_e                w_next;
    logic [TAP_W-1:0]            r_tap;
    logic [TAP_W-1:0]            r_locked;
    logic [CNT_W-1:0]            r_samples;
    logic [CNT_W-1:0]            r_ones;
    logic [CNT_W-1:0]            r_last;
    logic [WCNT_W-1:0]           r_wcnt;
    logic                        r_trig;
    logic                        r_done;
    logic                        r_ok;
    logic                        r_tmo;
    logic [CHALLENGE_WIDTH-1:0]  r_chal;
    logic [PDL_CONFIG_WIDTH-1:0] r_pdl;
    logic [PDL_CONFIG_WIDTH-1:0] w_therm;
    logic                        w_last_sample;
    logic                        w_wait_expired;
    logic                        w_last_tap;
    logic                        w_in_tol;
    int                          w_dev;

    therm_enc #(.WIDTH(PDL_CONFIG_WIDTH)) u_therm (
        .i_idx   (r_tap),
        .o_therm (w_therm)
    );

    assign w_last_sample  = (r_samples == CNT_W'(N_SAMPLES - 1));
    assign w_wait_expired = (r_wcnt == WCNT_W'(DONE_TIMEOUT - 1));
    assign w_last_tap     = (r_tap == TAP_W'(PDL_CONFIG_WIDTH));

    always_comb begin
        w_dev    = int'(r_ones) - HALF;
        w_in_tol = (w_dev <= TOL) && (w_dev >= -TOL);
    end

    always_ff @(posedge clk_1) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_TRIG;
            ST_TRIG:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (puf.puf_done)        w_next = w_last_sample ? ST_EVAL : ST_TRIG;
                else if (w_wait_expired) w_next = ST_FINISH;
            end
            ST_EVAL:   w_next = (w_in_tol || w_last_tap) ? ST_FINISH : ST_SETUP;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // The trigger is registered out of TRIG so the challenge latched there is valid alongside it.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_tap     <= '0;
            r_locked  <= '0;
            r_samples <= '0;
            r_ones    <= '0;
            r_last    <= '0;
            r_wcnt    <= '0;
            r_trig    <= 1'b0;
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_tmo     <= 1'b0;
            r_chal    <= '0;
            r_pdl     <= '0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tap  <= '0;
                        r_done <= 1'b0;
                        r_ok   <= 1'b0;
                        r_tmo  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_pdl     <= w_therm;
                    r_samples <= '0;
                    r_ones    <= '0;
                end
                ST_TRIG: begin
                    r_chal <= chal_in;
                    r_trig <= 1'b1;
                    r_wcnt <= '0;
                end
                ST_WAIT: begin
                    if (puf.puf_done) begin
                        r_samples <= r_samples + 1'b1;
                        r_ones    <= r_ones + {{(CNT_W-1){1'b0}}, puf.puf_xor_response};
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (w_wait_expired) begin
                            r_tmo <= 1'b1;
                            r_ok  <= 1'b0;
                        end
                    end
                end
                ST_EVAL: begin
                    r_last <= r_ones;
                    if (w_in_tol) begin
                        r_ok     <= 1'b1;
                        r_locked <= r_tap;
                    end else if (!w_last_tap) begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                ST_FINISH: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign puf.puf_trigger   = r_trig;
    assign puf.puf_challenge = r_chal;
    assign pdl_config        = r_pdl;
    assign busy              = (r_state != ST_IDLE);
    assign calib_done        = r_done;
    assign calib_ok          = r_ok;
    assign timeout_err       = r_tmo;
    assign locked_tap        = r_locked;
    assign last_ones         = r_last;
    assign dbg_state         = r_state;
endmodule

// File: tb/tb_puf_calib_ctrl.sv
// Bench for puf_calib_ctrl: a PUF responder driven by a per-tap ones table, and a
// sweep-level reference model predicting lock tap, ones count and trigger count.
module tb_puf_calib_ctrl;
    import puf_pkg::*;

    localparam int PW     = 128;
    localparam int CW     = 32;
    localparam int NS     = 64;
    localparam int HALF_N = 32;
    localparam int TOLV   = 4;
    localparam int TMO    = 255;

    typedef struct {
        bit ok;
        int tap;
        int last;
        int trig;
    } res_t;

    logic           clk_1;
    logic           rst;
    logic           start;
    logic [CW-1:0]  chal_in;
    logic [PW-1:0]  pdl_config;
    logic           busy;
    logic           calib_done;
    logic           calib_ok;
    logic           timeout_err;
    logic [7:0]     locked_tap;
    logic [7:0]     last_ones;
    calib_state_e   dbg_state;

    puf_calib_ctrl_if #(.CHALLENGE_WIDTH(CW)) puf_bus ();

    puf_calib_ctrl dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .start       (start),
        .chal_in     (chal_in),
        .puf         (puf_bus),
        .pdl_config  (pdl_config),
        .busy        (busy),
        .calib_done  (calib_done),
        .calib_ok    (calib_ok),
        .timeout_err (timeout_err),
        .locked_tap  (locked_tap),
        .last_ones   (last_ones),
        .dbg_state   (dbg_state)
    );

    // Stimulus knobs and shared state
    int      ones_tab [0:PW];
    int      run_id     = 0;
    int      fix_lat    = 3;
    int      perm_off   = 0;
    bit      rand_lat   = 1'b0;
    bit      never_done = 1'b0;
    bit      spur_en    = 1'b0;

    int      n_checks   = 0;
    int      n_errors   = 0;
    int      cyc        = 0;
    int      n_trig     = 0;
    int      any_trig   = 0;
    int      trig_tick  = 0;
    int      tmo_tick   = -1;
    bit      in_run     = 1'b0;
    bit      prev_trig  = 1'b0;
    logic [CW-1:0] prev_chal = '0;
    logic [CW-1:0] held_chal = '0;

    // Clock
    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] therm_of(input int t);
        logic [PW-1:0] m;
        for (int i = 0; i < PW; i++) m[i] = (i < t);
        return m;
    endfunction

    // Sweep-level reference: first tap whose ones count is within tolerance wins.
    function automatic res_t model();
        res_t r;
        int   d;
        r.ok = 1'b0; r.tap = 0; r.last = 0; r.trig = 0;
        for (int t = 0; t <= PW; t++) begin
            r.tap  = t;
            r.last = ones_tab[t];
            r.trig = (t + 1) * NS;
            d = ones_tab[t] - HALF_N;
            if (d < 0) d = -d;
            if (d <= TOLV) begin
                r.ok = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    // PUF responder: answers each trigger after a latency with a response drawn from ones_tab.
    initial begin : puf_model
        int seen_run, idx, cnt, tap, s;
        bit pending, resp_pend;
        seen_run = 0; idx = 0; cnt = 0; tap = 0; s = 0;
        pending = 1'b0; resp_pend = 1'b0;
        puf_bus.puf_done         = 1'b0;
        puf_bus.puf_xor_response = 1'b0;
        chal_in                  = '0;
        forever begin
            @(posedge clk_1);
            #1;
            if (run_id != seen_run) begin
                seen_run = run_id;
                idx      = 0;
                pending  = 1'b0;
            end
            chal_in = $urandom;
            if (puf_bus.puf_trigger && !never_done) begin
                s   = idx % NS;
                tap = idx / NS;
                if (tap > PW) tap = PW;
                resp_pend = ((((s * 37) + perm_off) % NS) < ones_tab[tap]);
                cnt       = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
                pending   = 1'b1;
                idx++;
            end
            puf_bus.puf_done         = 1'b0;
            puf_bus.puf_xor_response = 1'($urandom_range(0, 1));
            if (pending) begin
                if (cnt == 0) begin
                    puf_bus.puf_done         = 1'b1;
                    puf_bus.puf_xor_response = resp_pend;
                    pending                  = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (spur_en) begin
                puf_bus.puf_done         = 1'b1;
                puf_bus.puf_xor_response = 1'b1;
            end
        end
    end

    // One cycle: advance to the falling edge and compare every trigger / done against the model.
    task automatic tick();
        @(negedge clk_1);
        cyc++;
        if (puf_bus.puf_trigger) any_trig++;
        if (in_run) begin
            if (puf_bus.puf_trigger) begin
                chk("trig_single", 128'(prev_trig), 128'd0);
                chk("trig_busy", 128'(busy), 128'd1);
                chk("trig_chal", 128'(puf_bus.puf_challenge), 128'(prev_chal));
                chk("trig_pdl", 128'(pdl_config), 128'(therm_of(n_trig / NS)));
                held_chal = prev_chal;
                n_trig++;
                trig_tick = cyc;
            end
            if (puf_bus.puf_done && n_trig > 0) begin
                chk("wait_chal_hold", 128'(puf_bus.puf_challenge), 128'(held_chal));
                chk("wait_pdl_hold", 128'(pdl_config), 128'(therm_of((n_trig - 1) / NS)));
            end
        end
        if (timeout_err && tmo_tick < 0) tmo_tick = cyc;
        prev_trig = puf_bus.puf_trigger;
        prev_chal = chal_in;
    endtask

    task automatic run_calib(input int extra_start, input int budget, output bit got);
        run_id++;
        n_trig    = 0;
        prev_trig = 1'b0;
        tmo_tick  = -1;
        in_run    = 1'b1;
        got       = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'd1);
        chk("start_clr_done", 128'(calib_done), 128'd0);
        chk("start_clr_tmo", 128'(timeout_err), 128'd0);
        for (int i = 1; i < budget && !got; i++) begin
            if (i == extra_start) start = 1'b1;
            tick();
            start = 1'b0;
            if (calib_done) got = 1'b1;
        end
        in_run = 1'b0;
        chk("run_done_in_budget", 128'(got), 128'd1);
    endtask

    task automatic check_model(input string tag);
        res_t r;
        r = model();
        chk({tag, "_ok"}, 128'(calib_ok), 128'(r.ok));
        chk({tag, "_last_ones"}, 128'(last_ones), 128'(r.last));
        chk({tag, "_n_trig"}, 128'(n_trig), 128'(r.trig));
        chk({tag, "_pdl"}, 128'(pdl_config), 128'(therm_of(r.tap)));
        chk({tag, "_tmo"}, 128'(timeout_err), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        if (r.ok) chk({tag, "_locked"}, 128'(locked_tap), 128'(r.tap));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_trig"}, 128'(puf_bus.puf_trigger), 128'd0);
        chk({tag, "_chal"}, 128'(puf_bus.puf_challenge), 128'd0);
        chk({tag, "_pdl"}, 128'(pdl_config), 128'd0);
        chk({tag, "_done"}, 128'(calib_done), 128'd0);
        chk({tag, "_ok"}, 128'(calib_ok), 128'd0);
        chk({tag, "_tmo"}, 128'(timeout_err), 128'd0);
        chk({tag, "_locked"}, 128'(locked_tap), 128'd0);
        chk({tag, "_last"}, 128'(last_ones), 128'd0);
        chk({tag, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
    endtask

    initial begin : main_seq
        bit got;
        int lock, v;
        rst   = 1'b1;
        start = 1'b0;
        for (int t = 0; t <= PW; t++) ones_tab[t] = 0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Balanced at tap 0, with stray done pulses while idle beforehand
        ones_tab[0] = 32; fix_lat = 3; perm_off = 5;
        spur_en = 1'b1;
        repeat (6) tick();
        spur_en = 1'b0;
        repeat (2) tick();
        chk("idle_spur_busy", 128'(busy), 128'd0);
        run_calib(0, 5000, got);
        check_model("r030");
        chk("r030_ok_lit", 128'(calib_ok), 128'd1);
        chk("r030_locked_lit", 128'(locked_tap), 128'd0);
        chk("r030_last_lit", 128'(last_ones), 128'd32);
        chk("r030_trig_lit", 128'(n_trig), 128'd64);
        repeat (3) tick();
        chk("r030_done_sticky", 128'(calib_done), 128'd1);
        chk("r030_ok_sticky", 128'(calib_ok), 128'd1);

        // Saturated below tap 10, balanced at tap 10
        for (int t = 0; t <= PW; t++) ones_tab[t] = (t < 10) ? 64 : 30;
        perm_off = 17;
        run_calib(0, 10000, got);
        check_model("r031");
        chk("r031_locked_lit", 128'(locked_tap), 128'd10);
        chk("r031_pdl_lit", 128'(pdl_config), 128'h3FF);
        chk("r031_ok_lit", 128'(calib_ok), 128'd1);

        // Same sweep with a second start while busy
        run_calib(200, 10000, got);
        check_model("r035");
        chk("r035_locked_lit", 128'(locked_tap), 128'd10);
        chk("r035_trig_lit", 128'(n_trig), 128'd704);

        // PUF never answers
        never_done = 1'b1;
        run_calib(0, 2000, got);
        chk("r033_tmo", 128'(timeout_err), 128'd1);
        chk("r033_done", 128'(calib_done), 128'd1);
        chk("r033_ok", 128'(calib_ok), 128'd0);
        chk("r033_trig", 128'(n_trig), 128'd1);
        chk("r033_wait_cycles", 128'(tmo_tick - trig_tick), 128'(TMO));
        never_done = 1'b0;
        repeat (2) tick();

        // Tolerance edges: 27 and 37 rejected, 36 accepted
        for (int t = 0; t <= PW; t++) ones_tab[t] = 0;
        ones_tab[0] = 27; ones_tab[1] = 37; ones_tab[2] = 36;
        fix_lat = 2;
        run_calib(0, 5000, got);
        check_model("rbnd");
        chk("rbnd_locked_lit", 128'(locked_tap), 128'd2);
        chk("rbnd_last_lit", 128'(last_ones), 128'd36);

        // Randomized tables and latencies
        for (int k = 0; k < 4; k++) begin
            lock = $urandom_range(0, 4);
            for (int t = 0; t <= PW; t++) begin
                if (t == lock) begin
                    ones_tab[t] = $urandom_range(HALF_N - TOLV, HALF_N + TOLV);
                end else if (t < lock) begin
                    do v = $urandom_range(0, NS); while (v >= HALF_N - TOLV && v <= HALF_N + TOLV);
                    ones_tab[t] = v;
                end else begin
                    ones_tab[t] = $urandom_range(0, NS);
                end
            end
            perm_off = $urandom_range(0, NS - 1);
            rand_lat = 1'b1;
            run_calib(0, 10000, got);
            check_model("rnd");
        end
        rand_lat = 1'b0;

        // Reset while waiting at tap 5
        for (int t = 0; t <= PW; t++) ones_tab[t] = 0;
        fix_lat = 1;
        run_id++;
        n_trig = 0; prev_trig = 1'b0; in_run = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            tick();
            if (n_trig == 5 * NS + 1) got = 1'b1;
        end
        chk("r034_reach_t5", 128'(got), 128'd1);
        chk("r034_in_wait", 128'(dbg_state), 128'(ST_WAIT));
        in_run = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_vals("r034");
        rst = 1'b0;
        any_trig = 0;
        repeat (40) tick();
        chk("r034_no_trig", 128'(any_trig), 128'd0);

        // Full sweep with no lock
        fix_lat = 1;
        run_calib(0, 60000, got);
        check_model("r032");
        chk("r032_ok_lit", 128'(calib_ok), 128'd0);
        chk("r032_done_lit", 128'(calib_done), 128'd1);
        chk("r032_last_lit", 128'(last_ones), 128'd0);
        chk("r032_trig_lit", 128'(n_trig), 128'd8256);
        chk("r032_pdl_lit", 128'(pdl_config), {128{1'b1}});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/puf_calib_ctrl.md
PUF_CALIB_CTRL -- requirements
Module: puf_calib_ctrl

Interface
REQ-001 SHALL have parameter PDL_CONFIG_WIDTH, default 128, width of PDL tap configuration word.
REQ-002 SHALL have parameter CHALLENGE_WIDTH, default 32, width of PUF challenge.
REQ-003 SHALL have parameter N_SAMPLES, default 64, responses evaluated per tap setting (power of 2, 2..128).
REQ-004 SHALL have parameter TOL, default 4, allowed deviation of ones count from N_SAMPLES/2.
REQ-005 SHALL have parameter DONE_TIMEOUT, default 255, max cycles waiting for puf_done.
REQ-006 SHALL have ports: clk_1  in  1  FSM clock, all logic on rising edge; rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: start  in  1  single-cycle calibration request; chal_in  in  CHALLENGE_WIDTH  challenge from generator.
REQ-008 SHALL have ports: puf_done  in  1  PUF evaluation complete pulse; puf_xor_response  in  1  PUF response bit, valid with puf_done.
REQ-009 SHALL have ports: puf_trigger  out  1  one-cycle evaluation pulse; puf_challenge  out  CHALLENGE_WIDTH  registered challenge; pdl_config  out  PDL_CONFIG_WIDTH  tap setting.
REQ-010 SHALL have ports: busy  out  1; calib_done  out  1  sticky completion; calib_ok  out  1  lock found; timeout_err  out  1  sticky.
REQ-011 SHALL have ports: locked_tap  out  $clog2(PDL_CONFIG_WIDTH+1)  tap index; last_ones  out  8  ones count of last evaluated tap.

Function
REQ-012 SHALL implement states IDLE, SETUP, TRIG, WAIT, EVAL, FINISH.
REQ-013 IDLE: on start=1 SHALL clear tap index t, calib_done, calib_ok, timeout_err, go to SETUP next cycle; start ignored in all other states.
REQ-014 SETUP: SHALL drive pdl_config as thermometer code with low t bits set, others 0; clear sample and ones counters; go to TRIG.
REQ-015 TRIG: SHALL latch chal_in into puf_challenge and assert puf_trigger for exactly one cycle; go to WAIT.
REQ-016 WAIT: SHALL hold puf_challenge and pdl_config stable; on puf_done=1 SHALL add puf_xor_response to ones counter and increment sample counter.
REQ-017 WAIT: after puf_done, if sample counter reaches N_SAMPLES go to EVAL, else go to TRIG (minimum 2 cycles per sample).
REQ-018 WAIT: if DONE_TIMEOUT cycles elapse without puf_done, SHALL set timeout_err, calib_ok=0, go to FINISH.
REQ-019 EVAL: SHALL copy ones counter to last_ones; if |ones - N_SAMPLES/2| <= TOL, set calib_ok=1, locked_tap=t, go to FINISH.
REQ-020 EVAL: otherwise, if t == PDL_CONFIG_WIDTH go to FINISH with calib_ok=0, else t<=t+1 and go to SETUP.
REQ-021 FINISH: SHALL set calib_done=1 and return to IDLE next cycle; calib_done, calib_ok, locked_tap, pdl_config retained until next start.
REQ-022 busy SHALL be 1 in all states except IDLE.
REQ-023 Ones and sample counters SHALL be 8 bits and SHALL never wrap (N_SAMPLES <= 128).
REQ-024 puf_done asserted outside WAIT SHALL be ignored.
REQ-025 Sweep order SHALL be ascending t = 0..PDL_CONFIG_WIDTH; first matching tap wins.

Reset
REQ-026 On rst=1 at clk_1 edge: state=IDLE, puf_trigger=0, puf_challenge=0, pdl_config=0, busy=0, calib_done=0, calib_ok=0, timeout_err=0, locked_tap=0, last_ones=0, all counters 0.
REQ-027 rst SHALL take priority over start and over any mid-calibration state; no trigger pulse SHALL follow reset.

Structure
REQ-028 State encoding and default parameter constants SHALL reside in shared package puf_pkg.
REQ-029 Thermometer encoder (t -> pdl_config) SHALL be a separate sub-module therm_enc.

Verification
REQ-030 PUF model responding done 3 cycles after trigger, response = 1 for 32 of 64 at t=0 -> calib_ok=1, locked_tap=0, last_ones=32, exactly 64 trigger pulses.
REQ-031 Model ones count 64 for t<10, 30 at t=10 -> locked_tap=10, pdl_config=0x3FF, calib_ok=1.
REQ-032 Model always response 0 -> sweep to t=128, calib_ok=0, calib_done=1, last_ones=0, 129*64 triggers.
REQ-033 Model never asserts puf_done -> timeout_err=1 after 255 WAIT cycles, calib_done=1, calib_ok=0.
REQ-034 rst asserted during WAIT at t=5 -> next cycle all outputs at reset values, no puf_trigger until new start.
REQ-035 start pulsed while busy=1 -> ignored, sweep result identical to single-start run.
